// File: rtl/panda_pkg.sv
// rtl/panda_pkg.sv - shared ALU operator encoding
package panda_pkg;

  // Members are listed in the order the BIST visits them.
  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_XOR,
    ALU_OR,
    ALU_AND,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA
  } alu_operator_e;

  localparam int unsigned AluNumOps = 8;

endpackage

// File: rtl/panda_alu_bist.sv
// rtl/panda_alu_bist.sv - ALU self-test: LFSR operands, MISR signature, golden compare
// Optional macro PANDA_ALU_BIST_CORNER_EN prepends four fixed corner operand pairs.
module panda_alu_bist #(
  parameter int unsigned      Width      = 32,
  parameter int unsigned      NumVectors = 8,
  parameter logic [Width-1:0] Seed       = Width'(32'h0000_0001),
  parameter logic [Width-1:0] Poly       = Width'(32'h8020_0003),
  parameter logic [Width-1:0] GoldenSig  = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     pass_o,
  output logic [Width-1:0]         signature_o,
  output panda_pkg::alu_operator_e operator_o,
  output logic [Width-1:0]         operand_a_o,
  output logic [Width-1:0]         operand_b_o,
  input  logic [Width-1:0]         result_i
);

  localparam int unsigned NumOps = panda_pkg::AluNumOps;
  localparam int unsigned OpW    = $bits(panda_pkg::alu_operator_e);
`ifdef PANDA_ALU_BIST_CORNER_EN
  localparam int unsigned NumCorners = 4;
`else
  localparam int unsigned NumCorners = 0;
`endif
  localparam int unsigned TotalVectors = NumVectors + NumCorners;
  localparam int unsigned VecW         = $clog2(TotalVectors + 1);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SAMPLE, S_DONE} state_e;

  state_e                   r_state;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_pass;
  logic [Width-1:0]         r_sig;
  panda_pkg::alu_operator_e r_operator;
  logic [Width-1:0]         r_a;
  logic [Width-1:0]         r_b;
  logic [Width-1:0]         r_lfsr;
  logic [VecW-1:0]          r_vec_idx;

  logic [OpW-1:0]   w_op_idx;
  logic [OpW-1:0]   w_op_inc;
  logic [Width-1:0] w_sig_next;
  logic [Width-1:0] w_lfsr_adv;
  logic [Width-1:0] w_next_lfsr;
  logic [Width-1:0] w_next_a;
  logic [Width-1:0] w_next_b;

  function automatic logic [Width-1:0] step(input logic [Width-1:0] s);
    return (s >> 1) ^ ({Width{s[0]}} & Poly);
  endfunction

`ifdef PANDA_ALU_BIST_CORNER_EN
  function automatic logic [Width-1:0] corner_a(input logic [1:0] idx);
    case (idx)
      2'd0:    return '0;
      2'd1:    return '1;
      2'd2:    return {1'b1, {(Width-1){1'b0}}};
      default: return '1;
    endcase
  endfunction

  function automatic logic [Width-1:0] corner_b(input logic [1:0] idx);
    case (idx)
      2'd0:    return '0;
      2'd1:    return Width'(1);
      2'd2:    return '1;
      default: return Width'(Width - 1);
    endcase
  endfunction
`endif

  assign w_op_idx   = r_operator;
  assign w_op_inc   = w_op_idx + 1'b1;
  assign w_sig_next = {r_sig[Width-2:0], 1'b0} ^ ({Width{r_sig[Width-1]}} & Poly) ^ result_i;

  // Operand pair for the vector following r_vec_idx; the LFSR holds operand A.
  always_comb begin
    w_lfsr_adv  = step(step(r_lfsr));
    w_next_lfsr = w_lfsr_adv;
    w_next_a    = w_lfsr_adv;
    w_next_b    = step(w_lfsr_adv);
`ifdef PANDA_ALU_BIST_CORNER_EN
    if (r_vec_idx < VecW'(NumCorners - 1)) begin
      w_next_lfsr = r_lfsr;
      w_next_a    = corner_a(r_vec_idx[1:0] + 2'd1);
      w_next_b    = corner_b(r_vec_idx[1:0] + 2'd1);
    end else if (r_vec_idx == VecW'(NumCorners - 1)) begin
      w_next_lfsr = r_lfsr;
      w_next_a    = r_lfsr;
      w_next_b    = step(r_lfsr);
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_sig      <= '0;
      r_operator <= panda_pkg::alu_operator_e'(OpW'(0));
      r_a        <= '0;
      r_b        <= '0;
      r_lfsr     <= '0;
      r_vec_idx  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_state    <= S_APPLY;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_sig      <= '0;
            r_operator <= panda_pkg::alu_operator_e'(OpW'(0));
            r_vec_idx  <= '0;
            r_lfsr     <= Seed;
`ifdef PANDA_ALU_BIST_CORNER_EN
            r_a        <= corner_a(2'd0);
            r_b        <= corner_b(2'd0);
`else
            r_a        <= Seed;
            r_b        <= step(Seed);
`endif
          end else if (r_state == S_DONE) begin
            r_done <= 1'b1;
            r_pass <= (r_sig == GoldenSig);
          end
        end
        S_APPLY: r_state <= S_SAMPLE;
        S_SAMPLE: begin
          r_sig <= w_sig_next;
          if (w_op_idx != OpW'(NumOps - 1)) begin
            r_operator <= panda_pkg::alu_operator_e'(w_op_inc);
            r_state    <= S_APPLY;
          end else begin
            r_operator <= panda_pkg::alu_operator_e'(OpW'(0));
            r_lfsr     <= w_next_lfsr;
            r_a        <= w_next_a;
            r_b        <= w_next_b;
            r_vec_idx  <= r_vec_idx + 1'b1;
            if (r_vec_idx == VecW'(TotalVectors - 1)) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_APPLY;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign pass_o      = r_pass;
  assign signature_o = r_sig;
  assign operator_o  = r_operator;
  assign operand_a_o = r_a;
  assign operand_b_o = r_b;

endmodule

// File: tb/tb_panda_alu_bist.sv
// tb/tb_panda_alu_bist.sv - self-checking bench for panda_alu_bist against a signature model
module tb_panda_alu_bist;

  localparam int          W    = 32;
  localparam int          NV   = 2;
  localparam int          NOPS = 8;
  localparam logic [31:0] SEED = 32'h0000_0001;
  localparam logic [31:0] POLY = 32'h8020_0003;
`ifdef PANDA_ALU_BIST_CORNER_EN
  localparam int NC = 4;
`else
  localparam int NC = 0;
`endif
  localparam int TV      = NV + NC;
  localparam int RUN_LEN = 2 * NOPS * TV + 1;

  function automatic logic [31:0] step_f(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  function automatic logic [31:0] alu_f(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      0:       return a + b;
      1:       return a - b;
      2:       return a ^ b;
      3:       return a | b;
      4:       return a & b;
      5:       return a << b[4:0];
      6:       return a >> b[4:0];
      default: return 32'($signed(a) >>> b[4:0]);
    endcase
  endfunction

  function automatic logic [31:0] pair_a(input int v);
    logic [31:0] l;
    if (v < NC) begin
      case (v)
        0:       return 32'h0;
        1:       return 32'hFFFF_FFFF;
        2:       return 32'h8000_0000;
        default: return 32'hFFFF_FFFF;
      endcase
    end
    l = SEED;
    for (int i = 0; i < 2 * (v - NC); i++) l = step_f(l);
    return l;
  endfunction

  function automatic logic [31:0] pair_b(input int v);
    if (v < NC) begin
      case (v)
        0:       return 32'h0;
        1:       return 32'h1;
        2:       return 32'hFFFF_FFFF;
        default: return 32'd31;
      endcase
    end
    return step_f(pair_a(v));
  endfunction

  // Signature over every (vector, op) point; fault_pt flips result bit 0 at that point.
  function automatic logic [31:0] model_sig(input int fault_pt);
    logic [31:0] sig;
    logic [31:0] r;
    int pt;
    sig = 32'h0;
    pt  = 0;
    for (int v = 0; v < TV; v++) begin
      for (int op = 0; op < NOPS; op++) begin
        r = alu_f(op, pair_a(v), pair_b(v));
        if (pt == fault_pt) r = r ^ 32'h1;
        sig = (sig << 1) ^ (sig[31] ? POLY : 32'h0) ^ r;
        pt++;
      end
    end
    return sig;
  endfunction

  localparam logic [31:0] GOLD = model_sig(-1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic inj = 1'b0;

  logic busy, done, pass;
  logic [31:0] sig, a, b, res;
  panda_pkg::alu_operator_e op;
  logic busy_n, done_n, pass_n;
  logic [31:0] sig_n, a_n, b_n, res_n;
  panda_pkg::alu_operator_e op_n;

  assign res   = alu_f(int'(op), a, b) ^ {31'b0, inj};
  assign res_n = alu_f(int'(op_n), a_n, b_n) ^ {31'b0, inj};

  always #5 clk = ~clk;

  panda_alu_bist #(.Width(W), .NumVectors(NV), .Seed(SEED), .Poly(POLY), .GoldenSig(GOLD)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done), .pass_o(pass),
    .signature_o(sig), .operator_o(op), .operand_a_o(a), .operand_b_o(b), .result_i(res));

  panda_alu_bist #(.Width(W), .NumVectors(NV), .Seed(SEED), .Poly(POLY), .GoldenSig(GOLD ^ 32'h1)) u_dut_n (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy_n), .done_o(done_n), .pass_o(pass_n),
    .signature_o(sig_n), .operator_o(op_n), .operand_a_o(a_n), .operand_b_o(b_n), .result_i(res_n));

  int total = 0;
  int bad   = 0;
  int overlap;
  logic first_busy, first_done;
  int first_op;
  logic [31:0] obs_a [TV];
  logic [31:0] obs_b [TV];

  task automatic do_run(input int fault_pt, input bit disturb, output int len);
    len     = -1;
    overlap = 0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < RUN_LEN + 20; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 0) begin
        first_busy = busy;
        first_done = done;
        first_op   = int'(op);
      end
      if (cyc % (2 * NOPS) == 0 && cyc / (2 * NOPS) < TV) begin
        obs_a[cyc/(2*NOPS)] = a;
        obs_b[cyc/(2*NOPS)] = b;
      end
      if (busy && done) overlap++;
      if (done) begin
        len = cyc;
        break;
      end
      inj   = (cyc == 2 * fault_pt + 1);
      start = disturb && (cyc < RUN_LEN - 2) && ($urandom_range(0, 2) == 0);
    end
    start = 1'b0;
    inj   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin bad++;
      $display("FAIL reset_flags busy=%b done=%b pass=%b required 000", busy, done, pass); end
    total++; if (sig !== 32'h0) begin bad++; $display("FAIL reset_sig got=%h required=0", sig); end
    total++; if (int'(op) !== 0 || a !== 32'h0 || b !== 32'h0) begin bad++;
      $display("FAIL reset_drive op=%0d a=%h b=%h required 0/0/0", int'(op), a, b); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_golden_run;
    int len;
    do_run(-1, 1'b0, len);
    total++; if (first_busy !== 1'b1 || first_op !== 0) begin bad++;
      $display("FAIL first_apply busy=%b op=%0d required 1/0", first_busy, first_op); end
    for (int v = 0; v < TV; v++) begin
      total++; if (obs_a[v] !== pair_a(v) || obs_b[v] !== pair_b(v)) begin bad++;
        $display("FAIL pair%0d got=%h,%h required=%h,%h", v, obs_a[v], obs_b[v], pair_a(v), pair_b(v)); end
    end
    total++; if (len !== RUN_LEN) begin bad++; $display("FAIL run_len got=%0d required=%0d", len, RUN_LEN); end
    total++; if (overlap !== 0) begin bad++; $display("FAIL busy_done_overlap got=%0d required=0", overlap); end
    total++; if (sig !== GOLD) begin bad++; $display("FAIL golden_sig got=%h required=%h", sig, GOLD); end
    total++; if (pass !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL golden_pass pass=%b busy=%b required 1/0", pass, busy); end
    total++; if (sig_n !== GOLD || pass_n !== 1'b0 || done_n !== 1'b1) begin bad++;
      $display("FAIL wrong_golden sig=%h pass=%b done=%b required %h/0/1", sig_n, pass_n, done_n, GOLD); end
  endtask

  task automatic test_fault;
    int len;
    int k;
    k = $urandom_range(0, NOPS * TV - 1);
    do_run(k, 1'b0, len);
    total++; if (sig !== model_sig(k)) begin bad++;
      $display("FAIL fault_sig pt=%0d got=%h required=%h", k, sig, model_sig(k)); end
    total++; if (pass !== 1'b0 || len !== RUN_LEN) begin bad++;
      $display("FAIL fault_pass pass=%b len=%0d required 0/%0d", pass, len, RUN_LEN); end
  endtask

  task automatic test_start_ignored;
    int len;
    do_run(-1, 1'b1, len);
    total++; if (len !== RUN_LEN) begin bad++; $display("FAIL restart_len got=%0d required=%0d", len, RUN_LEN); end
    total++; if (sig !== GOLD || pass !== 1'b1) begin bad++;
      $display("FAIL restart_sig got=%h pass=%b required=%h/1", sig, pass, GOLD); end
  endtask

  task automatic test_reset_mid;
    int len;
    int m;
    m = $urandom_range(2, RUN_LEN - 3);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (m) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0 || sig !== 32'h0) begin bad++;
      $display("FAIL midreset busy=%b done=%b sig=%h required 0/0/0", busy, done, sig); end
    total++; if (int'(op) !== 0 || a !== 32'h0 || b !== 32'h0) begin bad++;
      $display("FAIL midreset_drive op=%0d a=%h b=%h required 0", int'(op), a, b); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++;
      $display("FAIL idle_hold busy=%b done=%b required 0/0", busy, done); end
    do_run(-1, 1'b0, len);
    total++; if (sig !== GOLD || len !== RUN_LEN) begin bad++;
      $display("FAIL rerun sig=%h len=%0d required %h/%0d", sig, len, GOLD, RUN_LEN); end
  endtask

  task automatic test_back_to_back;
    int len;
    repeat (4) @(negedge clk);
    total++; if (done !== 1'b1 || sig !== GOLD) begin bad++;
      $display("FAIL done_hold done=%b sig=%h required 1/%h", done, sig, GOLD); end
    do_run(-1, 1'b0, len);
    total++; if (first_done !== 1'b0 || first_busy !== 1'b1) begin bad++;
      $display("FAIL b2b_start done=%b busy=%b required 0/1", first_done, first_busy); end
    total++; if (sig !== GOLD || len !== RUN_LEN || pass !== 1'b1) begin bad++;
      $display("FAIL b2b_run sig=%h len=%0d pass=%b required %h/%0d/1", sig, len, pass, GOLD, RUN_LEN); end
  endtask

  initial begin
    test_reset();
    test_golden_run();
    test_fault();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/panda_alu_bist.md
# panda_alu_bist

Built-in self-test sequencer for `panda_alu`. It drives the ALU's `operator`/`operand_a`/`operand_b` inputs and consumes `result`. On request it steps every `alu_operator_e` value across a set of pseudo-random operand pairs and compresses each result into a MISR signature. At the end it compares the signature with a golden value, giving the core a single pass/fail ALU health check after reset.

## Interface
- `Width`, 32: datapath width; must match `panda_alu.Width`; ≥ 8.
- `NumVectors`, 8: number of LFSR operand pairs; ≥ 1.
- `Seed`, 32'h0000_0001: initial LFSR state; must be nonzero.
- `Poly`, 32'h8020_0003: feedback mask shared by the LFSR and the MISR.
- `GoldenSig`, 32'h0: expected final signature.

- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  one-cycle start pulse; honoured only in IDLE or DONE.
- `busy_o`  out  1  high from the cycle after an accepted start until DONE is entered.
- `done_o`  out  1  high in DONE; held until the next accepted start or reset.
- `pass_o`  out  1  `signature_o == GoldenSig`; meaningful only while `done_o` is high.
- `signature_o`  out  Width  MISR contents.
- `operator_o`  out  `panda_pkg::alu_operator_e`  to ALU `operator_i`.
- `operand_a_o`  out  Width  to ALU `operand_a_i`.
- `operand_b_o`  out  Width  to ALU `operand_b_i`.
- `result_i`  in  Width  from ALU `result_o`; the ALU is combinational.

## Operation
- States are IDLE, APPLY, SAMPLE and DONE.
- All outputs are registered. Reset values:
  - state = IDLE
  - `busy_o` = 0, `done_o` = 0, `pass_o` = 0
  - `signature_o` = 0
  - `operator_o` = enum index 0
  - `operand_a_o` = 0, `operand_b_o` = 0
- IDLE/DONE + `start_i`:
  - go to APPLY;
  - clear the MISR to 0 and `done_o`/`pass_o` to 0;
  - set op index = 0, vector index = 0, LFSR = `Seed`;
  - load `operand_a_o` = LFSR and `operand_b_o` = step(LFSR).
- APPLY: `operator_o` = enum value at the op index. Always go to SAMPLE.
- SAMPLE:
  - update the MISR: sig ← (sig << 1) ^ ({Width{sig[Width-1]}} & Poly) ^ `result_i`;
  - if op index < NumOps-1, increment the op index and go to APPLY;
  - otherwise reset the op index to 0, advance the LFSR two steps and load the new A/B pair, then:
    - go to APPLY if vectors remain;
    - go to DONE after the last vector.
- LFSR step: s' = (s >> 1) ^ ({Width{s[0]}} & Poly).
- NumOps is the member count of `alu_operator_e`. Ops are visited in declaration order.
- DONE: `done_o` = 1, `pass_o` = (sig == GoldenSig). Outputs freeze until the next start.
- `start_i` while busy is ignored; the run is not restarted.
- `rst_i` mid-run aborts to IDLE with all reset values, on the same edge.
- Simultaneous `rst_i` and `start_i`: reset wins.

## Timing
- Each (op, vector) point takes 2 cycles: APPLY drives, SAMPLE captures `result_i`.
- Run length: `start_i` sampled at edge 0 → `done_o` high after edge 2·NumOps·TotalVectors + 1.
- TotalVectors = NumVectors, or NumVectors + 4 with the configuration macro defined.
- Operator and operands are stable for the full APPLY and SAMPLE pair. The ALU path is a single cycle.
- `signature_o` changes only on SAMPLE edges.
- `busy_o` and `done_o` are never high together.

## Configuration
- Macro: `PANDA_ALU_BIST_CORNER_EN`.
- Defined: four fixed corner pairs run before the LFSR vectors, each across all operators:
  1. (0, 0)
  2. ('1, 1)
  3. (MSB-only, '1)
  4. ('1, Width-1)
- After the corner pairs, the LFSR pairs start from `Seed` as normal.
- Undefined: only the LFSR vectors run; the corner logic is absent.
- `GoldenSig` must be regenerated for each setting.

## Test plan
- Reset with `Width`=32, `NumVectors`=2 and the macro undefined; pulse `start_i` → first APPLY drives A=32'h1, B=32'h8020_0003 (step of 1). `done_o` rises exactly 4·NumOps+1 cycles after start.
- Reference-model run with `GoldenSig` set to the model's signature → `pass_o`=1. Same run with `GoldenSig`^1 → `pass_o`=0 and an identical `signature_o`.
- Force `result_i` bit 0 inverted on one SAMPLE only → final `signature_o` differs from golden and `pass_o`=0.
- Assert `start_i` during APPLY and SAMPLE mid-run → no restart, same length and signature as an undisturbed run.
- Assert `rst_i` mid-run → next cycle `busy_o`=0, `signature_o`=0, state IDLE. A fresh start then reproduces the golden signature.
- Macro defined, `NumVectors`=1 → first four operand pairs are (0,0), (FFFF_FFFF,1), (8000_0000,FFFF_FFFF), (FFFF_FFFF,31). Run length is 10·NumOps+1 cycles.
